icache_controller: RTL and testbench

- Direct-mapped instruction cache controller between the core fetch port and the byte-organised instruction memory.
- Memory returns 32-bit words, bytes assembled big-endian: addr+0 is bits [31:24] and addr+3 is bits [7:0].
- On a hit, returns the instruction combinationally, keeping the single-cycle core at full rate.
- On a miss, stalls the core and sequences a full line refill from instruction memory over a req/ack handshake.

---
 rtl/icache_pkg.sv | 25 ++
 rtl/icache_storage.sv | 60 ++++++
 rtl/icache_controller.sv | 206 ++++++++++++++++++++
 tb/tb_icache_controller.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and address-field width helpers for the instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic int unsigned offset_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned index_w(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  // Remaining high address bits after byte, word-offset and index fields.
  function automatic int unsigned tag_w(input int unsigned addr_width,
                                        input int unsigned line_words,
                                        input int unsigned num_lines);
    return addr_width - 2 - offset_w(line_words) - index_w(num_lines);
  endfunction

endpackage

// File: rtl/icache_storage.sv
// Data, tag and valid arrays of the direct-mapped instruction cache.
// Reads are combinational; one word is written per cycle. Tags and data
// carry no reset; valid bits clear on reset or on the clear strobe.
module icache_storage import icache_pkg::*; #(
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_LINES  = 4,
  parameter int unsigned TAG_W      = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [index_w(NUM_LINES)-1:0]     rd_index_i,
  input  logic [offset_w(LINE_WORDS)-1:0]   rd_offset_i,
  output logic [BUS_WIDTH-1:0]              rd_data_o,
  output logic [TAG_W-1:0]                  rd_tag_o,
  output logic                              rd_valid_o,
  input  logic                              wr_en_i,
  input  logic [index_w(NUM_LINES)-1:0]     wr_index_i,
  input  logic [offset_w(LINE_WORDS)-1:0]   wr_offset_i,
  input  logic [BUS_WIDTH-1:0]              wr_data_i,
  input  logic                              tag_we_i,
  input  logic [TAG_W-1:0]                  tag_data_i,
  input  logic                              set_valid_i,
  input  logic                              clear_i
);

  logic [BUS_WIDTH-1:0] data_q [NUM_LINES][LINE_WORDS];
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;

  assign rd_data_o  = data_q[rd_index_i][rd_offset_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_valid_o = valid_q[rd_index_i];

  // Refill word write; data array is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      data_q[wr_index_i][wr_offset_i] <= wr_data_i;
    end
  end

  // Tag write at line completion; tag array is not reset.
  always_ff @(posedge clk_i) begin
    if (tag_we_i) begin
      tag_q[wr_index_i] <= tag_data_i;
    end
  end

  // Valid bits: clear dominates set so a flush never leaves a fresh line valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (clear_i) begin
      valid_q <= '0;
    end else if (set_valid_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller: combinational hit path,
// stall-and-refill on miss over a single-outstanding req/ack memory port.
// Optional hit/miss counters are built when ICACHE_PERF_CNT_EN is defined.
module icache_controller import icache_pkg::*; #(
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_LINES  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_FetchReq,
  input  logic [ADDR_WIDTH-1:0] i_FetchAddress,
  input  logic                  i_Flush,
  output logic [BUS_WIDTH-1:0]  o_Instruction,
  output logic                  o_InstValid,
  output logic                  o_Stall,
  output logic                  o_MemReq,
  output logic [ADDR_WIDTH-1:0] o_MemAddress,
  input  logic [BUS_WIDTH-1:0]  i_MemData,
  input  logic                  i_MemAck
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]           o_HitCount,
  output logic [31:0]           o_MissCount
`endif
);

  localparam int unsigned OFFSET_W = offset_w(LINE_WORDS);
  localparam int unsigned INDEX_W  = index_w(NUM_LINES);
  localparam int unsigned TAG_W    = tag_w(ADDR_WIDTH, LINE_WORDS, NUM_LINES);
  localparam int unsigned LINE_W   = TAG_W + INDEX_W;

  state_e                state_q, state_d;
  logic [OFFSET_W-1:0]   k_q, k_d;
  logic [LINE_W-1:0]     line_q, line_d;
  logic                  pend_q, pend_d;

  logic [OFFSET_W-1:0]   fetch_offset;
  logic [INDEX_W-1:0]    fetch_index;
  logic [TAG_W-1:0]      fetch_tag;
  logic [LINE_W-1:0]     fetch_line;

  logic [BUS_WIDTH-1:0]  rd_data;
  logic [TAG_W-1:0]      rd_tag;
  logic                  rd_valid;
  logic                  hit;
  logic                  last_word;

  logic                  wr_en;
  logic                  tag_we;
  logic                  set_valid;
  logic                  clear;
  logic                  inst_valid;
  logic                  miss_start;

  assign fetch_offset = i_FetchAddress[OFFSET_W+1:2];
  assign fetch_index  = i_FetchAddress[OFFSET_W+2 +: INDEX_W];
  assign fetch_tag    = i_FetchAddress[ADDR_WIDTH-1 -: TAG_W];
  assign fetch_line   = i_FetchAddress[ADDR_WIDTH-1:OFFSET_W+2];

  assign hit       = (state_q == IDLE) && rd_valid && (rd_tag == fetch_tag);
  assign last_word = (k_q == OFFSET_W'(LINE_WORDS - 1));

  icache_storage #(
    .BUS_WIDTH  (BUS_WIDTH),
    .LINE_WORDS (LINE_WORDS),
    .NUM_LINES  (NUM_LINES),
    .TAG_W      (TAG_W)
  ) u_storage (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .rd_index_i  (fetch_index),
    .rd_offset_i (fetch_offset),
    .rd_data_o   (rd_data),
    .rd_tag_o    (rd_tag),
    .rd_valid_o  (rd_valid),
    .wr_en_i     (wr_en),
    .wr_index_i  (line_q[INDEX_W-1:0]),
    .wr_offset_i (k_q),
    .wr_data_i   (i_MemData),
    .tag_we_i    (tag_we),
    .tag_data_i  (line_q[LINE_W-1 -: TAG_W]),
    .set_valid_i (set_valid),
    .clear_i     (clear)
  );

  // FSM state, word counter, latched line address and pending flush.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      line_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      line_q  <= line_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state, storage control and core/memory outputs.
  // Everything stays at its default while reset is held, so the core-facing
  // outputs read zero immediately even with a fetch request present.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    line_d        = line_q;
    pend_d        = pend_q;
    wr_en         = 1'b0;
    tag_we        = 1'b0;
    set_valid     = 1'b0;
    clear         = 1'b0;
    inst_valid    = 1'b0;
    miss_start    = 1'b0;
    o_Stall       = 1'b0;
    o_MemReq      = 1'b0;
    o_MemAddress  = '0;
    o_Instruction = '0;
    if (!i_rst) begin
      unique case (state_q)
        IDLE: begin
          pend_d = 1'b0;
          clear  = i_Flush;
          if (i_FetchReq) begin
            if (hit && !i_Flush) begin
              inst_valid    = 1'b1;
              o_Instruction = rd_data;
            end else begin
              o_Stall    = 1'b1;
              miss_start = 1'b1;
              line_d     = fetch_line;
              k_d        = '0;
              state_d    = REFILL;
            end
          end
        end
        REFILL: begin
          o_Stall      = 1'b1;
          o_MemReq     = 1'b1;
          o_MemAddress = {line_q, k_q, 2'b00};
          if (i_Flush) begin
            pend_d = 1'b1;
          end
          if (i_MemAck) begin
            wr_en = 1'b1;
            if (last_word) begin
              tag_we    = 1'b1;
              set_valid = !(pend_q || i_Flush);
              clear     = pend_q || i_Flush;
              k_d       = '0;
              state_d   = DONE;
            end else begin
              k_d = k_q + OFFSET_W'(1);
            end
          end
        end
        DONE: begin
          o_Stall = 1'b1;
          // A flush arriving in this last stall cycle still applies.
          clear   = i_Flush;
          pend_d  = 1'b0;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign o_InstValid = inst_valid;

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Saturating next values for the performance counters.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (inst_valid && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if (miss_start && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  // Performance counter registers; untouched by flush.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign o_HitCount  = hit_cnt_q;
  assign o_MissCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Scoreboard bench for icache_controller: fetch stimulus pushes expected
// instructions and memory addresses; a monitor pops and compares them.
module tb_icache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [7:0]  fetch_addr = '0;
  logic        flush = 1'b0;
  logic [31:0] instr;
  logic        inst_valid;
  logic        stall;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data = '0;
  logic        mem_ack = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] exp_instr_q [$];
  logic [7:0]  exp_addr_q  [$];
  logic [7:0]  mem_bytes   [256];

  int unsigned ack_delay  = 0;
  bit          stray_ack  = 1'b0;
  int unsigned wait_cnt   = 0;
  bit          prev_wait  = 1'b0;
  logic [7:0]  prev_addr  = '0;

  always #5 clk = ~clk;

  icache_controller #(
    .BUS_WIDTH  (32),
    .ADDR_WIDTH (8),
    .LINE_WORDS (4),
    .NUM_LINES  (4)
  ) dut (
`ifdef ICACHE_PERF_CNT_EN
    .o_HitCount     (hit_cnt),
    .o_MissCount    (miss_cnt),
`endif
    .i_clk          (clk),
    .i_rst          (rst),
    .i_FetchReq     (fetch_req),
    .i_FetchAddress (fetch_addr),
    .i_Flush        (flush),
    .o_Instruction  (instr),
    .o_InstValid    (inst_valid),
    .o_Stall        (stall),
    .o_MemReq       (mem_req),
    .o_MemAddress   (mem_addr),
    .i_MemData      (mem_data),
    .i_MemAck       (mem_ack)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Big-endian assembly of the byte-organised instruction memory.
  function automatic logic [31:0] word_at(input logic [7:0] a);
    return {mem_bytes[a], mem_bytes[8'(a + 8'd1)], mem_bytes[8'(a + 8'd2)], mem_bytes[8'(a + 8'd3)]};
  endfunction

  task automatic put_word(input logic [7:0] a, input logic [31:0] w);
    mem_bytes[a]               = w[31:24];
    mem_bytes[8'(a + 8'd1)]    = w[23:16];
    mem_bytes[8'(a + 8'd2)]    = w[15:8];
    mem_bytes[8'(a + 8'd3)]    = w[7:0];
  endtask

  // Memory responder: acks after ack_delay waiting cycles per word.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_req) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack  = 1'b1;
        mem_data = word_at(mem_addr);
        wait_cnt = 0;
      end else begin
        mem_ack  = 1'b0;
        mem_data = 32'hBAD0BAD0;
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      mem_ack  = stray_ack;
      mem_data = stray_ack ? 32'hDEADBEEF : 32'h0;
    end
  end

  // Monitor: compares presented instructions and acked addresses to the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (inst_valid) begin
        if (exp_instr_q.size() == 0) flag_fail("unexpected_instvalid");
        else check("instruction", instr, exp_instr_q.pop_front());
      end else begin
        check("instr_zero_when_invalid", instr, 32'h0);
      end
      if (mem_req && mem_ack) begin
        if (exp_addr_q.size() == 0) flag_fail("unexpected_memreq");
        else check("mem_address", {24'h0, mem_addr}, {24'h0, exp_addr_q.pop_front()});
      end
      if (mem_req && !mem_ack && prev_wait) begin
        check("mem_address_stable", {24'h0, mem_addr}, {24'h0, prev_addr});
      end
      prev_wait = mem_req && !mem_ack;
      prev_addr = mem_addr;
    end else begin
      prev_wait = 1'b0;
    end
  end

  // Fetch one address, holding the request until the cache presents it.
  task automatic fetch(input logic [7:0] a, input logic [31:0] exp,
                       input int unsigned refills, input int unsigned exp_stall);
    int unsigned stalls;
    bit          got;
    logic [7:0]  base;
    base = {a[7:4], 4'h0};
    exp_instr_q.push_back(exp);
    for (int unsigned r = 0; r < refills; r++)
      for (int unsigned w = 0; w < 4; w++)
        exp_addr_q.push_back(8'(base + 8'(4 * w)));
    @(posedge clk); #1;
    fetch_req  = 1'b1;
    fetch_addr = a;
    stalls = 0;
    got    = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (inst_valid) got = 1'b1;
      else if (stall) stalls++;
    end
    if (!got) flag_fail("fetch_timeout");
    check("stall_cycles", stalls, exp_stall);
    @(posedge clk); #1;
    fetch_req = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_instr"},     instr, 32'h0);
    check({tag, "_instvalid"}, {31'h0, inst_valid}, 32'h0);
    check({tag, "_stall"},     {31'h0, stall}, 32'h0);
    check({tag, "_memreq"},    {31'h0, mem_req}, 32'h0);
    check({tag, "_memaddr"},   {24'h0, mem_addr}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    for (int i = 0; i < 256; i++) mem_bytes[i] = 8'(i) ^ 8'h5C;
    put_word(8'h00, 32'h002001B3);
    put_word(8'h04, 32'h402180B3);
    put_word(8'h08, 32'h001F0FB3);
    put_word(8'h0C, 32'h00802F03);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold miss, then same-cycle hits (low address bits ignored)
    fetch(8'h00, 32'h002001B3, 1, 6);
    fetch(8'h04, 32'h402180B3, 0, 0);
    fetch(8'h08, 32'h001F0FB3, 0, 0);
    fetch(8'h0E, 32'h00802F03, 0, 0);

    // Stray ack with no request must not write the cache
    @(posedge clk); #1;
    stray_ack = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    stray_ack = 1'b0;
    repeat (2) @(posedge clk);
    fetch(8'h00, 32'h002001B3, 0, 0);

    // Conflict on index 0
    fetch(8'h40, word_at(8'h40), 1, 6);
    fetch(8'h00, 32'h002001B3, 1, 6);

    // Slow memory: three waiting cycles per word
    ack_delay = 3;
    fetch(8'h30, word_at(8'h30), 1, 18);
    ack_delay = 0;
    fetch(8'h34, word_at(8'h34), 0, 0);

    // Flush mid-refill: line not validated, held fetch refills again
    fork
      fetch(8'h10, word_at(8'h10), 2, 12);
      begin
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
      end
    join
    fetch(8'h00, 32'h002001B3, 1, 6);

    // Flush in IDLE invalidates every line
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    fetch(8'h10, word_at(8'h10), 1, 6);
    fetch(8'h00, 32'h002001B3, 1, 6);

    // Reset during word 2 of a refill
    exp_addr_q.push_back(8'h20);
    exp_addr_q.push_back(8'h24);
    exp_addr_q.push_back(8'h28);
    @(posedge clk); #1;
    fetch_req  = 1'b1;
    fetch_addr = 8'h20;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 8'h28) found = 1'b1;
    end
    if (!found) flag_fail("refill_word2_timeout");
    #1 rst = 1'b1;
    #1 check_outputs_zero("midreset");
    @(posedge clk); #1;
    fetch_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    fetch(8'h20, word_at(8'h20), 1, 6);
    fetch(8'h2C, word_at(8'h2C), 0, 0);

    repeat (3) @(posedge clk);
    if (exp_instr_q.size() != 0) flag_fail("instr_queue_not_empty");
    if (exp_addr_q.size() != 0) flag_fail("addr_queue_not_empty");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
